// File: rtl/snow3g_keystream.sv
// SNOW 3G keystream stage: takes the initialised LFSR/FSM state, performs the one
// discarded keystream-mode clock, then hands out len words z = F ^ s0 over valid/ready.
module snow3g_keystream #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [511:0]     LFSR_in,
    input  logic [95:0]      FSM_in,
    input  logic [LEN_W-1:0] len,
    output logic [31:0]      z,
    output logic             z_valid,
    input  logic             z_ready,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, DISCARD, RUN, FIN} state_t;

    state_t           state, state_nxt;
    logic [31:0]      s [16];
    logic [31:0]      r1, r2, r3;
    logic [LEN_W-1:0] cnt;
    logic [31:0]      f, r1_nxt, r2_nxt, r3_nxt, v;
    logic             step;

    function automatic logic [7:0] mulx(input logic [7:0] x, input logic [7:0] c);
        return x[7] ? ({x[6:0], 1'b0} ^ c) : {x[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] mulx_pow(input logic [7:0] x, input int n, input logic [7:0] c);
        logic [7:0] y;
        y = x;
        for (int i = 0; i < n; i++) y = mulx(y, c);
        return y;
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        logic [7:0] acc, sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = mulx(sh, c);
        end
        return acc;
    endfunction

    // AES S-box: inverse as x^254 in GF(2^8) mod 0x11B, followed by the affine map
    function automatic logic [7:0] sr(input logic [7:0] x);
        logic [7:0] p, y;
        p = x;
        y = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p = gf_mul(p, p, 8'h1b);
            y = gf_mul(y, p, 8'h1b);
        end
        return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
    endfunction

    // SQ: Dickson polynomial g49 over GF(2^8) mod 0x169, offset by 0x25
    function automatic logic [7:0] sq_box(input logic [7:0] x);
        logic [7:0] x2, x4, x8, x16, x32, x9, x13, x15, x33, x41, x45, x47, x49;
        x2  = gf_mul(x,   x,   8'h69);
        x4  = gf_mul(x2,  x2,  8'h69);
        x8  = gf_mul(x4,  x4,  8'h69);
        x16 = gf_mul(x8,  x8,  8'h69);
        x32 = gf_mul(x16, x16, 8'h69);
        x9  = gf_mul(x8,  x,   8'h69);
        x13 = gf_mul(x9,  x4,  8'h69);
        x15 = gf_mul(x13, x2,  8'h69);
        x33 = gf_mul(x32, x,   8'h69);
        x41 = gf_mul(x33, x8,  8'h69);
        x45 = gf_mul(x41, x4,  8'h69);
        x47 = gf_mul(x45, x2,  8'h69);
        x49 = gf_mul(x47, x2,  8'h69);
        return x ^ x9 ^ x13 ^ x15 ^ x33 ^ x41 ^ x45 ^ x47 ^ x49 ^ 8'h25;
    endfunction

    function automatic logic [31:0] mix(input logic [7:0] a0, input logic [7:0] a1,
                                        input logic [7:0] a2, input logic [7:0] a3,
                                        input logic [7:0] c);
        return {mulx(a0, c) ^ a1 ^ a2 ^ mulx(a3, c) ^ a3,
                mulx(a0, c) ^ a0 ^ mulx(a1, c) ^ a2 ^ a3,
                a0 ^ mulx(a1, c) ^ a1 ^ mulx(a2, c) ^ a3,
                a0 ^ a1 ^ mulx(a2, c) ^ a2 ^ mulx(a3, c)};
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] w);
        return mix(sr(w[31:24]), sr(w[23:16]), sr(w[15:8]), sr(w[7:0]), 8'h1b);
    endfunction

    function automatic logic [31:0] s2(input logic [31:0] w);
        return mix(sq_box(w[31:24]), sq_box(w[23:16]), sq_box(w[15:8]), sq_box(w[7:0]), 8'h69);
    endfunction

    function automatic logic [31:0] mul_alpha(input logic [7:0] c);
        return {mulx_pow(c, 23, 8'ha9), mulx_pow(c, 245, 8'ha9),
                mulx_pow(c, 48, 8'ha9), mulx_pow(c, 239, 8'ha9)};
    endfunction

    function automatic logic [31:0] div_alpha(input logic [7:0] c);
        return {mulx_pow(c, 16, 8'ha9), mulx_pow(c, 39, 8'ha9),
                mulx_pow(c, 6, 8'ha9), mulx_pow(c, 64, 8'ha9)};
    endfunction

    always_comb begin
        f      = (s[15] + r1) ^ r2;
        r1_nxt = r2 + (r3 ^ s[5]);
        r2_nxt = s1(r1);
        r3_nxt = s2(r2);
        v      = {s[0][23:0], 8'h00} ^ mul_alpha(s[0][31:24]) ^ s[2]
               ^ {8'h00, s[11][31:8]} ^ div_alpha(s[11][7:0]);
        z_valid   = (state == RUN);
        z         = z_valid ? (f ^ s[0]) : 32'h0;
        busy      = (state != IDLE);
        done      = (state == FIN);
        step      = (state == DISCARD) || ((state == RUN) && z_ready);
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = DISCARD;
            DISCARD: state_nxt = (cnt == '0) ? FIN : RUN;
            RUN:     if (z_ready && (cnt == LEN_W'(1))) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            r1    <= '0;
            r2    <= '0;
            r3    <= '0;
            for (int i = 0; i < 16; i++) s[i] <= '0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && start) begin
                for (int i = 0; i < 16; i++) s[i] <= LFSR_in[511-32*i -: 32];
                r1  <= FSM_in[95:64];
                r2  <= FSM_in[63:32];
                r3  <= FSM_in[31:0];
                cnt <= len;
            end else if (step) begin
                // keystream-mode clock: no F feedback into the LFSR
                for (int i = 0; i < 15; i++) s[i] <= s[i+1];
                s[15] <= v;
                r1    <= r1_nxt;
                r2    <= r2_nxt;
                r3    <= r3_nxt;
                if (state == RUN) cnt <= cnt - LEN_W'(1);
            end
        end
    end
endmodule

// File: doc/snow3g_keystream.md
# snow3g_keystream

Keystream-generation stage of the SNOW 3G core, directly downstream of the `Initialize` block. It takes the 512-bit LFSR state and 96-bit FSM state that `Initialize` produces after its 32 initialisation clocks, and performs the single discarded keystream-mode clock. It then emits a requested number of 32-bit keystream words `z` over a valid/ready handshake to the cipher/XOR stage.

## Interface
- `LEN_W`, default 16: width of the word-count request.
- `clk` input, 1: system clock; all state changes on its rising edge.
- `rst` input, 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `start` input, 1: load request, honoured only in IDLE.
- `LFSR_in` input, 512: initialised LFSR; s0 = [511:480] … s15 = [31:0].
- `FSM_in` input, 96: initialised FSM; R1 = [95:64], R2 = [63:32], R3 = [31:0].
- `len` input, `LEN_W`: number of keystream words to emit; sampled with `start`.
- `z` output, 32: keystream word; forced to 0 whenever `z_valid` = 0.
- `z_valid` output, 1: `z` holds a valid word.
- `z_ready` input, 1: downstream accepts `z` this cycle.
- `busy` output, 1: high in every state except IDLE.
- `done` output, 1: single-cycle pulse when the request completes.

## Operation
- Registers:
  - s0..s15, 32 bits each.
  - R1, R2, R3, 32 bits each.
  - word counter `cnt` (`LEN_W` bits).
  - state: IDLE, DISCARD, RUN, FIN.
- IDLE + `start` = 1: load s0..s15 from `LFSR_in`, R1..R3 from `FSM_in`, and `cnt` from `len`; go to DISCARD. `start` is ignored in every other state.
- Step (shared by DISCARD and each RUN handshake):
  - F = (s15 ⊞ R1) ⊕ R2.
  - r = R2 ⊞ (R3 ⊕ s5).
  - R3 ← S2(R2); R2 ← S1(R1); R1 ← r.
  - v = (s0 << 8) ⊕ MULα(s0[31:24]) ⊕ s2 ⊕ (s11 >> 8) ⊕ DIVα(s11[7:0]).
  - Shift s_i ← s_{i+1}, then s15 ← v.
  - ⊞ is addition mod 2^32, with carries discarded. There is no F feedback into the LFSR (keystream mode).
- S1, S2, MULα and DIVα are the ETSI/SAGE SNOW 3G functions, identical to those used by `Initialize`.
- DISCARD: perform one step, drop F.
  - If `cnt` = 0, go to FIN.
  - Otherwise go to RUN.
- RUN:
  - `z_valid` = 1 and `z` = F ⊕ s0, computed combinationally from the current registers.
  - On `z_valid && z_ready`: perform one step and decrement `cnt`.
  - If `cnt` was 1, go to FIN.
  - Without `z_ready`, all registers hold and `z` stays stable.
- FIN: `done` = 1 for this cycle, then go to IDLE. LFSR/FSM contents are retained but unused.

## Timing
- Reset values:
  - state = IDLE.
  - s0..s15, R1..R3 and `cnt` = 0.
  - `z` = 0, `z_valid` = 0, `busy` = 0, `done` = 0.
- `rst` has priority over everything, including a concurrent `start`. Reset mid-RUN aborts immediately: no `done`, and `z_valid` = 0 from the next cycle.
- Latency with `start` sampled at edge 0:
  - Cycle 1 is DISCARD.
  - The first `z_valid` = 1 appears in cycle 2.
  - With `z_ready` tied high, word n is presented in cycle n+1, and `done` is high in cycle `len`+2.
- `len` = 0: DISCARD in cycle 1, `done` in cycle 2, `z_valid` never asserted.
- Maximum `len` = 2^`LEN_W`−1, with no wrap. `cnt` never decrements below 0.
- `busy` is high from the cycle after `start` through the FIN cycle inclusive. A new `start` is accepted in the cycle after FIN.
- All state changes are registered; the only combinational paths are `z` and `z_valid` from registers. Neither depends on `z_ready`.

## Test plan
- ETSI test set 1: K = 2bd6459f 82c5b300 952c4910 4881ff48, IV = ea024714 ad5c4d84 df1f9b25 1c0bf45f through `Initialize` into this block, `len` = 2, `z_ready` = 1 → z = abee9704 then 7ac31373; `done` 4 cycles after `start`.
- Same vector with `z_ready` toggled 1-0-0-1 → each word is held stable while not accepted, the sequence is unchanged, and `done` follows the 2nd accepted word.
- `len` = 0 → no `z_valid`; `done` in cycle 2; `busy` high in cycles 1–2 only.
- `start` pulsed again during RUN with different `LFSR_in` → ignored; the output sequence is identical to an undisturbed run.
- `rst` asserted after the first word of a `len` = 4 run → the next cycle shows `z_valid` = 0, `busy` = 0, `z` = 0, with no `done`. A fresh `start` then reproduces abee9704 first.
- `len` = 1000 with `z_ready` = 1 → exactly 1000 handshakes, and `done` at cycle 1002. Words are compared against a software SNOW 3G model.
